// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - MIPS pipeline interlock: load-use stalls, HI/LO interlock, branch flushes, stall counter.
// HI/LO interlock (FSM, busy counter, HL term) is built only when HILO_INTERLOCK_EN is defined.
module hazard_stall_unit #(
   parameter int MULDIV_LAT  = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [4:0]             IDrs,
   input  logic [4:0]             IDrt,
   input  logic                   IDUsesRs,
   input  logic                   IDUsesRt,
   input  logic                   IDReadHI,
   input  logic                   IDReadLO,
   input  logic                   EXMemRead,
   input  logic                   EXRegWrite,
   input  logic [4:0]             EXDstReg,
   input  logic                   EXMulDiv,
   input  logic                   EXBranchTaken,
   output logic                   PCWrite,
   output logic                   IFIDWrite,
   output logic                   IFIDFlush,
   output logic                   IDEXFlush,
   output logic                   HiLoBusy,
   output logic [STALL_CNT_W-1:0] StallCount
);

   logic lu;
   logic hl;
   logic stall;
   logic hilo_pending;

   assign lu = EXMemRead & EXRegWrite & (EXDstReg != 5'd0) &
               ((IDUsesRs & (IDrs == EXDstReg)) | (IDUsesRt & (IDrt == EXDstReg)));

`ifdef HILO_INTERLOCK_EN
   typedef enum logic {RUN, HILO_BUSY} state_t;

   localparam logic [3:0] BC_LOAD = 4'(MULDIV_LAT - 1);

   state_t     state;
   logic [3:0] bc;

   // bc counts the remaining HILO_BUSY cycles; the FSM leaves as bc runs out
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= RUN;
         bc    <= 4'd0;
      end else if (EXMulDiv) begin
         state <= (BC_LOAD == 4'd0) ? RUN : HILO_BUSY;
         bc    <= BC_LOAD;
      end else if (state == HILO_BUSY) begin
         if (bc <= 4'd1) begin
            state <= RUN;
            bc    <= 4'd0;
         end else begin
            bc <= bc - 4'd1;
         end
      end
   end

   assign hilo_pending = EXMulDiv | (state == HILO_BUSY);
   assign hl           = (IDReadHI | IDReadLO) & hilo_pending;
`else
   // Constant zero; the HI/LO inputs stay referenced so the port list is unchanged
   assign hilo_pending = 1'b0;
   assign hl           = 1'b0 & (IDReadHI | IDReadLO | EXMulDiv | (MULDIV_LAT < 1));
`endif

   assign stall    = (lu | hl) & ~EXBranchTaken;
   assign HiLoBusy = ~Rst & hilo_pending;

   always_comb begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      if (Rst) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (EXBranchTaken) begin
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (stall) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IDEXFlush = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         StallCount <= '0;
      end else if (!PCWrite && (StallCount != '1)) begin
         StallCount <= StallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit with directed vectors.
// Expectations follow HILO_INTERLOCK_EN when the bench is compiled with the same macro.
module tb_hazard_stall_unit;

   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic [4:0]    IDrs = '0, IDrt = '0, EXDstReg = '0;
   logic          IDUsesRs = 0, IDUsesRt = 0, IDReadHI = 0, IDReadLO = 0;
   logic          EXMemRead = 0, EXRegWrite = 0, EXMulDiv = 0, EXBranchTaken = 0;
   logic          PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, HiLoBusy;
   logic [CW-1:0] StallCount;

   hazard_stall_unit #(.MULDIV_LAT(4), .STALL_CNT_W(CW)) dut (
      .Clk(Clk), .Rst(Rst), .IDrs(IDrs), .IDrt(IDrt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
      .IDReadHI(IDReadHI), .IDReadLO(IDReadLO), .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite),
      .EXDstReg(EXDstReg), .EXMulDiv(EXMulDiv), .EXBranchTaken(EXBranchTaken),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
      .HiLoBusy(HiLoBusy), .StallCount(StallCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int            id;
      logic [3:0]    ctl;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
      logic          busy;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

`ifdef HILO_INTERLOCK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   localparam logic [3:0] C_RST = 4'b0011, C_RUN = 4'b1100, C_STL = 4'b0001, C_BR = 4'b1111;

   // inputs: rst, rs, rt, urs, urt, rhi, rlo, mr, rw, dst, md, bt
   task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rhi, input logic rlo,
                       input logic mr, input logic rw, input logic [4:0] dst,
                       input logic md, input logic bt,
                       input logic [3:0] ctl, input logic busy, input logic [CW-1:0] cnt);
      exp_t e;
      @(posedge Clk);
      #1;
      Rst = rst; IDrs = rs; IDrt = rt; IDUsesRs = urs; IDUsesRt = urt;
      IDReadHI = rhi; IDReadLO = rlo; EXMemRead = mr; EXRegWrite = rw;
      EXDstReg = dst; EXMulDiv = md; EXBranchTaken = bt;
      e.id = step_id; e.ctl = ctl; e.busy = busy; e.cnt = cnt;
      exp_q.push_back(e);
      step_id++;
   endtask

   task automatic idle(input logic [3:0] ctl, input logic busy, input logic [CW-1:0] cnt);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, busy, cnt);
   endtask

   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [3:0] got;
         e = exp_q.pop_front();
         got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
         checks++;
         if (got !== e.ctl || HiLoBusy !== e.busy || StallCount !== e.cnt) begin
            errors++;
            $display("FAIL step%0d: got ctl=%b busy=%b cnt=%0d, required ctl=%b busy=%b cnt=%0d",
                     e.id, got, HiLoBusy, StallCount, e.ctl, e.busy, e.cnt);
         end
      end
   end

   initial begin
      // reset state
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0, C_RST, 0, 0);
      idle(C_RUN, 0, 0);
      // load-use on rs, then bubble
      step(0, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 0, C_STL, 0, 0);
      idle(C_RUN, 0, 1);
      // hazard on $0 never stalls
      step(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, C_RUN, 0, 1);
      // load-use on rt
      step(0, 3, 7, 1, 1, 0, 0, 1, 1, 7, 0, 0, C_STL, 0, 1);
      // rt matches but is not read
      step(0, 3, 7, 1, 0, 0, 0, 1, 1, 7, 0, 0, C_RUN, 0, 2);
      // branch overrides load-use
      step(0, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 1, C_BR, 0, 2);
      idle(C_RUN, 0, 2);
      // mult at t, mfhi waiting in decode t..t+4
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, EN ? C_STL : C_RUN, EN, 2);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN ? C_STL : C_RUN, EN, EN ? 3 : 2);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN ? C_STL : C_RUN, EN, EN ? 4 : 2);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN ? C_STL : C_RUN, EN, EN ? 5 : 2);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN, 0, EN ? 6 : 2);
      // back-to-back mult/div, mflo released at t+5
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, EN, EN ? 6 : 2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, EN, EN ? 6 : 2);
      idle(C_RUN, EN, EN ? 6 : 2);
      idle(C_RUN, EN, EN ? 6 : 2);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EN ? C_STL : C_RUN, EN, EN ? 6 : 2);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN, 0, EN ? 7 : 2);
      // reset while HILO_BUSY with bc=2
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, EN, EN ? 7 : 2);
      idle(C_RUN, EN, EN ? 7 : 2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);
      // counter saturates at 2^CW-1
      for (int i = 0; i < 20; i++) begin
         step(0, 9, 0, 1, 0, 0, 0, 1, 1, 9, 0, 0, C_STL, 0, (i > 15) ? CW'(15) : CW'(i));
      end
      idle(C_RUN, 0, 15);
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge Clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
